// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter in the sys_clk domain.
// A baud clock-enable counter paces each line bit (CLK_COUNT = SYS_CLK_FREQ/BAUD_RATE).
// Frame: start(0), DATA_WIDTH bits LSB first, optional parity, STOP_BITS stop(1).
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit
// (even parity, or odd when PARITY_ODD=1).
module uart_tx_fifo #(
    parameter int SYS_CLK_FREQ = 1000000,
    parameter int BAUD_RATE    = 9600,
    parameter int DATA_WIDTH   = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                        sys_clk,
    input  logic                        sreset,
    input  logic                        data_valid,
    input  logic [DATA_WIDTH-1:0]       data_in,
    output logic                        data_ready,
    output logic                        data_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CLK_COUNT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int CNT_W     = (CLK_COUNT > 1) ? $clog2(CLK_COUNT) : 1;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    // DATA_WIDTH >= 5 gives at least 3 index bits, which also covers the stop-bit index
    localparam int IDX_W     = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        baud_cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
`ifdef UART_TX_PARITY_EN
    logic                    par_bit;
`endif

    logic baud_tick;
    logic stop_done;
    logic fifo_empty;
    logic push;
    logic pop;

    // Parity of a payload word: XOR of all bits, inverted for odd parity
    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] w);
        return (^w) ^ (PARITY_ODD != 0);
    endfunction

    assign baud_tick  = (baud_cnt == CNT_W'(CLK_COUNT - 1));
    assign stop_done  = baud_tick && (state == ST_STOP) && (bit_idx == IDX_W'(STOP_BITS - 1));
    assign fifo_empty = (fifo_count == '0);
    // Head is consumed either from idle or exactly as the last stop bit ends (no idle gap)
    assign pop        = !fifo_empty && ((state == ST_IDLE) || stop_done);
    assign data_ready = (fifo_count != (PTR_W + 1)'(FIFO_DEPTH));
    assign push       = data_valid && data_ready;
    assign busy       = (state != ST_IDLE) || !fifo_empty;

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge sys_clk) begin
        if (sreset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the count gates every read
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    // Payload shift register: loaded on pop, shifted right as each bit goes out
    always_ff @(posedge sys_clk) begin
        if (pop) begin
            shift_reg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            par_bit   <= parity_of(mem[rd_ptr]);
`endif
        end else if (baud_tick && (state == ST_START || state == ST_DATA)) begin
            shift_reg <= shift_reg >> 1;
        end
    end

    // Frame sequencer with registered line output and baud counter
    always_ff @(posedge sys_clk) begin
        if (sreset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            data_out <= 1'b1;
        end else begin
            // idle holds the counter at zero, so entering START always begins a full bit
            if (state == ST_IDLE || baud_tick) baud_cnt <= '0;
            else                               baud_cnt <= baud_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    data_out <= 1'b1;
                    if (pop) begin
                        state    <= ST_START;
                        data_out <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        state    <= ST_DATA;
                        bit_idx  <= '0;
                        data_out <= shift_reg[0];
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state    <= ST_PARITY;
                            data_out <= par_bit;
`else
                            state    <= ST_STOP;
                            data_out <= 1'b1;
                            bit_idx  <= '0;
`endif
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            data_out <= shift_reg[0];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_tick) begin
                        state    <= ST_STOP;
                        data_out <= 1'b1;
                        bit_idx  <= '0;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_tick) begin
                        if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
                            if (pop) begin
                                state    <= ST_START;
                                data_out <= 1'b0;
                            end else begin
                                state    <= ST_IDLE;
                                data_out <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    data_out <= 1'b1;
                end
            endcase
        end
    end

endmodule
